// File: rtl/key_search_pkg.sv
// Shared types and defaults for the RC4 key search scheduler and its round-robin arbiter.
// Optional performance counters in the top are enabled by defining KEY_SEARCH_PERF_CNT_EN.
package key_search_pkg;

    localparam int KEY_WIDTH_DEFAULT = 24;
    localparam logic [KEY_WIDTH_DEFAULT-1:0] KEY_MAX_DEFAULT = 24'h3FFFFF;

    typedef logic [KEY_WIDTH_DEFAULT-1:0] key_t;

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        RUN,
        FOUND,
        EXHAUSTED
    } sched_state_t;

    // Index width that stays legal for a single-core build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_search_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks one requester starting at i_rr_ptr;
// priority requesters (cores reporting a good key) pre-empt plain requesters.
module rr_arbiter
    import key_search_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_pri_req,
    input  logic [IW-1:0] i_rr_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_grant_valid
);

    logic [N-1:0] w_pool;
    int           w_idx;

    assign w_pool = (|i_pri_req) ? i_pri_req : i_req;

    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_idx         = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(i_rr_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!o_grant_valid && w_pool[w_idx]) begin
                o_grant_valid  = 1'b1;
                o_grant_idx    = IW'(w_idx);
                o_grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_search_scheduler.sv
// Schedules the 24-bit RC4 key search over NUM_CORES decryption cores.
// Define KEY_SEARCH_PERF_CNT_EN to add the keys_tested / search_cycles counters.
module key_search_scheduler
    import key_search_pkg::*;
#(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = KEY_WIDTH_DEFAULT,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(KEY_MAX_DEFAULT)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_ok,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    output logic [NUM_CORES-1:0]           core_new_key,
    output logic                           busy,
    output logic                           found,
    output logic                           exhausted,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [idx_width(NUM_CORES)-1:0] found_core
`ifdef KEY_SEARCH_PERF_CNT_EN
    ,
    output logic [KEY_WIDTH:0]             keys_tested,
    output logic [31:0]                    search_cycles
`endif
);

    localparam int IW = idx_width(NUM_CORES);

    sched_state_t           r_state, w_state_next;
    logic [KEY_WIDTH:0]     r_next_key;
    logic [IW-1:0]          r_disp_idx, r_rr_ptr, r_found_core;
    logic [NUM_CORES-1:0]   r_retired, r_new_key, r_block;
    logic [KEY_WIDTH-1:0]   r_core_key [NUM_CORES];
    logic [KEY_WIDTH-1:0]   r_found_key;

    logic [NUM_CORES-1:0]   w_req, w_pri_req, w_grant;
    logic [IW-1:0]          w_grant_idx, w_target_idx;
    logic                   w_grant_valid, w_keys_left, w_launch;
    logic                   w_assign, w_retire, w_verdict, w_latch_found;

    // A core is not eligible during its new-key pulse or the cycle after,
    // giving it time to drop the stale done level.
    assign w_req       = core_done & ~r_retired & ~r_new_key & ~r_block
                         & {NUM_CORES{r_state == RUN}};
    assign w_pri_req   = w_req & core_ok;
    assign w_keys_left = (r_next_key <= {1'b0, KEY_MAX});

    rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_arb (
        .i_req         (w_req),
        .i_pri_req     (w_pri_req),
        .i_rr_ptr      (r_rr_ptr),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    always_comb begin
        w_state_next  = r_state;
        w_launch      = 1'b0;
        w_assign      = 1'b0;
        w_retire      = 1'b0;
        w_verdict     = 1'b0;
        w_latch_found = 1'b0;
        w_target_idx  = r_disp_idx;
        case (r_state)
            IDLE, FOUND, EXHAUSTED: begin
                if (start) begin
                    w_launch     = 1'b1;
                    w_state_next = DISPATCH;
                end
            end
            DISPATCH: begin
                w_assign = w_keys_left;
                w_retire = !w_keys_left;
                if (r_disp_idx == IW'(NUM_CORES - 1)) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (&r_retired) begin
                    w_state_next = EXHAUSTED;
                end else if (w_grant_valid) begin
                    w_verdict    = 1'b1;
                    w_target_idx = w_grant_idx;
                    if (|(w_grant & core_ok)) begin
                        w_latch_found = 1'b1;
                        w_state_next  = FOUND;
                    end else begin
                        w_assign = w_keys_left;
                        w_retire = !w_keys_left;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_next_key   <= '0;
            r_disp_idx   <= '0;
            r_rr_ptr     <= '0;
            r_retired    <= '0;
            r_new_key    <= '0;
            r_block      <= '0;
            r_found_key  <= '0;
            r_found_core <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                r_core_key[i] <= '0;
            end
        end else begin
            r_state   <= w_state_next;
            r_new_key <= '0;
            r_block   <= r_new_key;
            if (w_launch) begin
                r_next_key <= '0;
                r_retired  <= '0;
                r_disp_idx <= '0;
            end
            if (r_state == DISPATCH) begin
                r_disp_idx <= r_disp_idx + 1'b1;
            end
            if (w_assign) begin
                r_core_key[w_target_idx] <= r_next_key[KEY_WIDTH-1:0];
                r_new_key[w_target_idx]  <= 1'b1;
                r_next_key               <= r_next_key + 1'b1;
            end
            if (w_retire) begin
                r_retired[w_target_idx] <= 1'b1;
            end
            if (w_verdict) begin
                r_rr_ptr <= (w_grant_idx == IW'(NUM_CORES - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            if (w_latch_found) begin
                r_found_key  <= r_core_key[w_grant_idx];
                r_found_core <= w_grant_idx;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_key_out
        assign core_key[gi*KEY_WIDTH +: KEY_WIDTH] = r_core_key[gi];
    end

    assign core_new_key = r_new_key;
    assign busy         = (r_state == DISPATCH) || (r_state == RUN);
    assign found        = (r_state == FOUND);
    assign exhausted    = (r_state == EXHAUSTED);
    assign found_key    = r_found_key;
    assign found_core   = r_found_core;

`ifdef KEY_SEARCH_PERF_CNT_EN
    logic [KEY_WIDTH:0] r_keys_tested;
    logic [31:0]        r_search_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_keys_tested   <= '0;
            r_search_cycles <= '0;
        end else if (w_launch) begin
            r_keys_tested   <= '0;
            r_search_cycles <= '0;
        end else begin
            if (w_verdict) begin
                r_keys_tested <= r_keys_tested + 1'b1;
            end
            if (busy && (r_search_cycles != 32'hFFFF_FFFF)) begin
                r_search_cycles <= r_search_cycles + 1'b1;
            end
        end
    end

    assign keys_tested   = r_keys_tested;
    assign search_cycles = r_search_cycles;
`endif

endmodule
